// File: rtl/mskand_hpc3_stream.sv
// HPC3 masked AND over W parallel bits with d shares; registered U/V/A/T stage feeding a combinational share recombination.
// Latency 1 cycle; valid/ready stage that holds every register while out_valid & ~out_ready, stalls when rnd is absent.
module mskand_hpc3_stream #(
  parameter int d    = 2,
  parameter int W    = 1,
  parameter int FULL = 1,
  parameter int CW   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [d*W-1:0]         ina,
  input  logic [d*W-1:0]         inb,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W*d*(d-1)-1:0]   rnd,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  output logic [d*W-1:0]         out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CW-1:0]          rnd_cnt
);

  localparam int P  = d * (d - 1) / 2;
  localparam int RB = 2 * P;
  localparam int NP = d * (d - 1);

  // Dense index of ordered pair (i,j), i != j, into the U/V register arrays.
  function automatic int pidx(input int i, input int j);
    return i * (d - 1) + ((j < i) ? j : j - 1);
  endfunction

  // Upper-triangle index of unordered pair {i,j}; r0/r1 are symmetric.
  function automatic int kidx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * d - lo * (lo + 1) / 2 + (hi - 1 - lo);
  endfunction

  logic [W-1:0]  r_u [NP];
  logic [W-1:0]  r_v [NP];
  logic [W-1:0]  r_a [d];
  logic [W-1:0]  r_t [d];
  logic          r_out_valid;
  logic [CW-1:0] r_cnt;

  logic [W-1:0]  w_u [NP];
  logic [W-1:0]  w_v [NP];
  logic [W-1:0]  w_t [d];
  logic          w_rdy;
  logic          w_fire;

  assign w_rdy     = ~r_out_valid | out_ready;
  assign w_fire    = in_valid & rnd_valid & w_rdy;
  assign in_ready  = rnd_valid & w_rdy;
  assign rnd_ready = in_valid & w_rdy;
  assign out_valid = r_out_valid;
  assign rnd_cnt   = r_cnt;

  always_comb begin : next_state
    for (int p = 0; p < NP; p++) begin
      w_u[p] = '0;
      w_v[p] = '0;
    end
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        if (i != j) begin
          for (int b = 0; b < W; b++) begin
            w_u[pidx(i, j)][b] = (~ina[i*W+b] & rnd[b*RB+kidx(i, j)]) ^ rnd[b*RB+P+kidx(i, j)];
            w_v[pidx(i, j)][b] = inb[j*W+b] ^ rnd[b*RB+kidx(i, j)];
          end
        end
      end
    end
    for (int i = 0; i < d; i++) begin
      w_t[i] = (FULL != 0) ? (ina[i*W +: W] & inb[i*W +: W]) : '0;
    end
  end

  // Recombination only touches registered terms, so out is stable during a stall.
  always_comb begin : recombine
    logic [W-1:0] acc;
    acc = '0;
    out = '0;
    for (int i = 0; i < d; i++) begin
      acc = r_t[i];
      for (int j = 0; j < d; j++) begin
        if (i != j) begin
          acc = acc ^ r_u[pidx(i, j)] ^ (r_a[i] & r_v[pidx(i, j)]);
        end
      end
      out[i*W +: W] = acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        r_u[p] <= '0;
        r_v[p] <= '0;
      end
      for (int i = 0; i < d; i++) begin
        r_a[i] <= '0;
        r_t[i] <= '0;
      end
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_fire) begin
        for (int p = 0; p < NP; p++) begin
          r_u[p] <= w_u[p];
          r_v[p] <= w_v[p];
        end
        for (int i = 0; i < d; i++) begin
          r_a[i] <= ina[i*W +: W];
          r_t[i] <= w_t[i];
        end
      end
      if (w_fire) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_fire && (r_cnt != {CW{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mskand_hpc3_stream.sv
// Directed d=2 vectors (full and cross-only, with a CW=3 counter) plus a d=3, W=4 random sweep against a golden product.
module tb_mskand_hpc3_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // d=2, W=1 stimulus shared by the full and cross-only instances
  logic [1:0]  p_ina, p_inb, p_rnd;
  logic        p_iv, p_rv, p_ordy;
  logic [1:0]  a_out, b_out;
  logic        a_ov, a_ir, a_rr, b_ov, b_ir, b_rr;
  logic [15:0] a_cnt;
  logic [2:0]  b_cnt;

  // d=3, W=4 stimulus shared by the sweep instances
  logic [11:0] s_ina, s_inb;
  logic [23:0] s_rnd;
  logic        s_iv, s_rv, s_ordy;
  logic [11:0] f_out, c_out;
  logic        f_ov, f_ir, f_rr, c_ov, c_ir, c_rr;
  logic [15:0] f_cnt, c_cnt;

  mskand_hpc3_stream #(.d(2), .W(1), .FULL(1), .CW(16)) u_full2 (
    .clk(clk), .rst_n(rst_n), .ina(p_ina), .inb(p_inb), .in_valid(p_iv), .in_ready(a_ir),
    .rnd(p_rnd), .rnd_valid(p_rv), .rnd_ready(a_rr), .out(a_out), .out_valid(a_ov),
    .out_ready(p_ordy), .rnd_cnt(a_cnt));

  mskand_hpc3_stream #(.d(2), .W(1), .FULL(0), .CW(3)) u_crs2 (
    .clk(clk), .rst_n(rst_n), .ina(p_ina), .inb(p_inb), .in_valid(p_iv), .in_ready(b_ir),
    .rnd(p_rnd), .rnd_valid(p_rv), .rnd_ready(b_rr), .out(b_out), .out_valid(b_ov),
    .out_ready(p_ordy), .rnd_cnt(b_cnt));

  mskand_hpc3_stream #(.d(3), .W(4), .FULL(1), .CW(16)) u_full3 (
    .clk(clk), .rst_n(rst_n), .ina(s_ina), .inb(s_inb), .in_valid(s_iv), .in_ready(f_ir),
    .rnd(s_rnd), .rnd_valid(s_rv), .rnd_ready(f_rr), .out(f_out), .out_valid(f_ov),
    .out_ready(s_ordy), .rnd_cnt(f_cnt));

  mskand_hpc3_stream #(.d(3), .W(4), .FULL(0), .CW(16)) u_crs3 (
    .clk(clk), .rst_n(rst_n), .ina(s_ina), .inb(s_inb), .in_valid(s_iv), .in_ready(c_ir),
    .rnd(s_rnd), .rnd_valid(s_rv), .rnd_ready(c_rr), .out(c_out), .out_valid(c_ov),
    .out_ready(s_ordy), .rnd_cnt(c_cnt));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic [1:0] a, input logic [1:0] b, input logic [1:0] r);
    p_ina = a;
    p_inb = b;
    p_rnd = r;
  endtask

  function automatic logic [3:0] unm(input logic [11:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8];
  endfunction

  logic       mvld;
  logic [3:0] m_full, m_crs;
  logic       exp_rdy, fire;
  int         n_fire, n_drain;

  initial begin
    rst_n = 1'b0;
    p_ina = '0; p_inb = '0; p_rnd = '0; p_iv = 1'b0; p_rv = 1'b0; p_ordy = 1'b1;
    s_ina = '0; s_inb = '0; s_rnd = '0; s_iv = 1'b0; s_rv = 1'b0; s_ordy = 1'b1;
    tick();
    tick();
    chk("rst_out",   a_out, 2'b00);
    chk("rst_ov",    a_ov,  1'b0);
    chk("rst_cnt",   a_cnt, 16'd0);
    chk("rst_ir",    a_ir,  1'b0);
    chk("rst_out_b", b_out, 2'b00);
    p_rv = 1'b1;
    #1;
    chk("ir_rv_only", a_ir, 1'b1);
    chk("rr_no_inv",  a_rr, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    // a=(1,0) b=(0,1) r0=1 r1=0
    p_iv = 1'b1;
    drive2(2'b01, 2'b10, 2'b01);
    #1;
    chk("v1_ir", a_ir, 1'b1);
    chk("v1_rr", a_rr, 1'b1);
    tick();
    chk("v1_out_full",  a_out, 2'b10);
    chk("v1_ov",        a_ov,  1'b1);
    chk("v1_cnt",       a_cnt, 16'd1);
    chk("v1_out_cross", b_out, 2'b10);
    chk("v1_cnt_b",     b_cnt, 3'd1);

    // a=(1,1) b=(1,1)
    drive2(2'b11, 2'b11, 2'b01);
    tick();
    chk("v2_out_full",  a_out, 2'b11);
    chk("v2_out_cross", b_out, 2'b00);
    chk("v2_cnt",       a_cnt, 16'd2);

    // a=(0,1) b=(1,1) r0=1 r1=1 held off by out_ready=0
    p_ordy = 1'b0;
    drive2(2'b10, 2'b11, 2'b11);
    #1;
    chk("bp_ir", a_ir, 1'b0);
    chk("bp_rr", a_rr, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_out",    a_out, 2'b11);
      chk("bp_out_b",  b_out, 2'b00);
      chk("bp_ov",     a_ov,  1'b1);
      chk("bp_cnt",    a_cnt, 16'd2);
      chk("bp_ir_hold", a_ir, 1'b0);
      chk("bp_rr_hold", a_rr, 1'b0);
    end
    p_ordy = 1'b1;
    #1;
    chk("pt_ir", a_ir, 1'b1);
    tick();
    chk("v3_out_full",  a_out, 2'b00);
    chk("v3_out_cross", b_out, 2'b10);
    chk("v3_cnt",       a_cnt, 16'd3);
    // a=(1,1) b=(0,1) r0=0 r1=1
    drive2(2'b11, 2'b10, 2'b10);
    tick();
    chk("v4_out_full",  a_out, 2'b00);
    chk("v4_out_cross", b_out, 2'b10);
    chk("v4_cnt",       a_cnt, 16'd4);
    chk("v4_ov",        a_ov,  1'b1);

    p_rv = 1'b0;
    #1;
    chk("st_ir", a_ir, 1'b0);
    chk("st_rr", a_rr, 1'b1);
    tick();
    chk("st_ov",   a_ov,  1'b0);
    chk("st_cnt",  a_cnt, 16'd4);
    chk("st_hold", b_out, 2'b10);
    tick();
    chk("st_cnt2", a_cnt, 16'd4);
    p_iv = 1'b0;
    p_rv = 1'b1;
    #1;
    chk("noin_rr", a_rr, 1'b0);
    chk("noin_ir", a_ir, 1'b1);
    tick();
    chk("noin_cnt", a_cnt, 16'd4);
    chk("noin_ov",  a_ov,  1'b0);

    // Fill, stall, then reset between clock edges.
    p_iv = 1'b1;
    p_ordy = 1'b0;
    drive2(2'b01, 2'b10, 2'b01);
    tick();
    chk("fill_out", a_out, 2'b10);
    chk("fill_cnt", a_cnt, 16'd5);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out",   a_out, 2'b00);
    chk("ar_ov",    a_ov,  1'b0);
    chk("ar_cnt",   a_cnt, 16'd0);
    chk("ar_cnt_b", b_cnt, 3'd0);
    chk("ar_out_b", b_out, 2'b00);
    chk("ar_ir",    a_ir,  1'b1);

    @(negedge clk);
    rst_n = 1'b1;
    p_ordy = 1'b1;
    repeat (10) tick();
    chk("sat_cnt_b", b_cnt, 3'd7);
    chk("sat_cnt_a", a_cnt, 16'd10);
    p_iv = 1'b0;

    mvld = 1'b0;
    n_fire = 0;
    n_drain = 0;
    m_full = '0;
    m_crs = '0;
    for (int cyc = 0; cyc < 40000 && n_fire < 10000; cyc++) begin
      s_iv   = ($urandom_range(7) != 0);
      s_rv   = ($urandom_range(7) != 0);
      s_ordy = ($urandom_range(7) != 0);
      s_ina  = 12'($urandom);
      s_inb  = 12'($urandom);
      s_rnd  = 24'($urandom);
      #1;
      exp_rdy = ~mvld | s_ordy;
      chk("sw_ir",   f_ir, s_rv & exp_rdy);
      chk("sw_rr",   f_rr, s_iv & exp_rdy);
      chk("sw_rr_c", c_rr, s_iv & exp_rdy);
      fire = s_iv & s_rv & exp_rdy;
      if (f_ov && s_ordy) n_drain++;
      if (fire) begin
        n_fire++;
        m_full = unm(s_ina) & unm(s_inb);
        m_crs = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            if (i != j) m_crs = m_crs ^ (s_ina[i*4 +: 4] & s_inb[j*4 +: 4]);
      end
      mvld = fire | (mvld & ~s_ordy);
      tick();
      chk("sw_ov", f_ov, mvld);
      if (mvld) begin
        chk("sw_full",  unm(f_out), m_full);
        chk("sw_cross", unm(c_out), m_crs);
      end
    end
    chk("sw_fires",   n_fire, 10000);
    chk("sw_cnt",     f_cnt, n_fire);
    chk("sw_cnt_c",   c_cnt, n_fire);
    chk("sw_vld_sum", n_drain + int'(f_ov), n_fire);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
